// File: rtl/capture_sequencer_pkg.sv
// Shared definitions for the capture path: sample width and sequencer state encoding.
// SAMPLE_W is also used by the sample mux and packer_12to8.
package capture_sequencer_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PPS = 2'd1,
        ST_RUN      = 2'd2,
        ST_DONE     = 2'd3
    } capState_e;

endpackage

// File: rtl/capture_sequencer_if.sv
// Control, status and sample-path signals of the capture sequencer.
// The register block drives master; the sequencer is slave.
interface capture_sequencer_if #(
    parameter int CNT_W = 32
);
    import capture_sequencer_pkg::*;

    logic                start;
    logic                abort;
    logic                cfg_pps_align;
    logic [CNT_W-1:0]    cfg_count;
    logic                pps;
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                adc_enable;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_data;
    logic                busy;
    logic                done;
    logic                timeout;
    logic [CNT_W-1:0]    sample_cnt;

    modport master (
        output start, abort, cfg_pps_align, cfg_count, pps, in_valid, in_data,
        input  adc_enable, out_valid, out_data, busy, done, timeout, sample_cnt
    );

    modport slave (
        input  start, abort, cfg_pps_align, cfg_count, pps, in_valid, in_data,
        output adc_enable, out_valid, out_data, busy, done, timeout, sample_cnt
    );

endinterface

// File: rtl/capture_timeout_cnt.sv
// Loadable down-counter that flags expiry of the PPS wait window.
// Holds at zero once expired; ENABLE=0 means the window never expires.
module capture_timeout_cnt
    import capture_sequencer_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] LOAD_VALUE = '0,
    parameter bit               ENABLE     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [WIDTH-1:0] remain_q;
    logic [WIDTH-1:0] remain_d;

    always_comb begin
        remain_d = remain_q;
        if (load_i) begin
            remain_d = LOAD_VALUE;
        end else if (en_i && (remain_q != '0)) begin
            remain_d = remain_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign expired_o = ENABLE && (remain_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Gates the sample stream into the packer for one capture: optional PPS alignment,
// bounded or unbounded sample count, abort, and status for registers/LEDs.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 160000000
) (
    input  logic                 clock,
    input  logic                 reset,
    capture_sequencer_if.slave   bus
);

    // Counter loads TIMEOUT_CYCLES-1 on start and expires on the last allowed WAIT_PPS cycle.
    localparam int             TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);

    capState_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
    logic             timeout_q, timeout_d;
    logic             busy_q;
    logic             pps_q;
    logic             ppsEdge;
    logic             toLoad;
    logic             toEn;
    logic             toExpired;
    logic             passSample;

    capture_timeout_cnt #(
        .WIDTH      (TO_W),
        .LOAD_VALUE (TO_LOAD),
        .ENABLE     (TO_EN)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .load_i    (toLoad),
        .en_i      (toEn),
        .expired_o (toExpired)
    );

    assign ppsEdge    = bus.pps & ~pps_q;
    assign passSample = (state_q == ST_RUN) && bus.in_valid;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sampleCnt_d = sampleCnt_q;
        timeout_d   = timeout_q;
        toLoad      = 1'b0;
        toEn        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    count_d     = bus.cfg_count;
                    sampleCnt_d = '0;
                    timeout_d   = 1'b0;
                    toLoad      = 1'b1;
                    state_d     = bus.cfg_pps_align ? ST_WAIT_PPS : ST_RUN;
                end
            end
            ST_WAIT_PPS: begin
                toEn = 1'b1;
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (ppsEdge) begin
                    state_d = ST_RUN;
                end else if (toExpired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Sample passed on an abort cycle is still counted, since it reached the packer.
                if (bus.in_valid) begin
                    if (sampleCnt_q != '1) begin
                        sampleCnt_d = sampleCnt_q + CNT_W'(1);
                    end
                    if ((count_q != '0) && (sampleCnt_q == count_q - CNT_W'(1))) begin
                        state_d = ST_DONE;
                    end
                end
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            sampleCnt_q <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            pps_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sampleCnt_q <= sampleCnt_d;
            timeout_q   <= timeout_d;
            busy_q      <= (state_d != ST_IDLE);
            pps_q       <= bus.pps;
        end
    end

    assign bus.adc_enable = (state_q == ST_RUN);
    assign bus.out_valid  = passSample;
    assign bus.out_data   = passSample ? bus.in_data : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.timeout    = timeout_q;
    assign bus.sample_cnt = sampleCnt_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized scoreboard bench for capture_sequencer: a timeline model of each capture
// predicts passed samples and per-cycle status, and a negedge monitor compares them.
module tb_capture_sequencer;
    import capture_sequencer_pkg::*;

    localparam int CNT_W = 32;
    localparam int TOC   = 64;
    localparam int MAXC  = 3000;

    typedef logic [CNT_W+3:0] status_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    capture_sequencer_if #(.CNT_W(CNT_W)) bus ();

    capture_sequencer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    status_t             statusQ[$];
    logic [SAMPLE_W-1:0] expQ[$];
    int                  nChecks = 0;
    int                  nPass   = 0;
    bit                  monOn   = 1'b0;
    logic                expTo   = 1'b0;
    logic [CNT_W-1:0]    expCnt  = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endfunction

    // Status fields packed as {busy, adc_enable, done, timeout, sample_cnt}.
    always @(negedge clock) begin
        status_t e;
        if (monOn) begin
            if (statusQ.size() > 0) begin
                e = statusQ.pop_front();
                check("status", 64'({bus.busy, bus.adc_enable, bus.done, bus.timeout, bus.sample_cnt}), 64'(e));
            end
            if (bus.out_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpectedSample: actual=0x%0h required=no sample", bus.out_data);
                end else begin
                    check("outData", 64'(bus.out_data), 64'(expQ.pop_front()));
                end
            end else begin
                check("gatedOutput", 64'({bus.out_valid, bus.out_data}), 64'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            reset = 1'b0;
            statusQ.push_back({1'b0, 1'b0, 1'b0, expTo, expCnt});
            bus.start         = 1'b0;
            bus.abort         = 1'($urandom_range(1));
            bus.in_valid      = 1'($urandom_range(1));
            bus.in_data       = SAMPLE_W'($urandom);
            bus.pps           = 1'($urandom_range(1));
            bus.cfg_pps_align = 1'($urandom_range(1));
            bus.cfg_count     = CNT_W'($urandom_range(0, 20));
        end
    endtask

    // Cycle 0 issues start; the capture window, its end and the done cycle follow from the rules.
    task automatic applyStimulus(input int n, input bit align, input int ppsAt, input int abortAt,
                                 input int resetAt, input int validPct, input bit noise);
        int winStart = -1;
        int endCycle = -1;
        int doneAt   = -1;
        int passed   = 0;
        bit stopped  = 1'b0;
        bit finished = 1'b0;
        for (int c = 0; c <= MAXC; c++) begin
            bit busyE, inRun, inWait, abortNow, resetNow, v;
            logic [SAMPLE_W-1:0] data;
            tick();
            busyE  = (c >= 1) && (endCycle < 0 || c <= endCycle);
            inRun  = (winStart >= 1) && (c >= winStart) && !stopped;
            inWait = align && (c >= 1) && (winStart < 0) && !stopped;
            statusQ.push_back({busyE, inRun, (c == doneAt), expTo, expCnt});
            abortNow = (c == abortAt) && (c == 0 || busyE);
            resetNow = (c == resetAt) && (c >= 1);
            v        = ($urandom_range(99) < validPct);
            data     = SAMPLE_W'($urandom);

            reset        = resetNow;
            bus.start    = (c == 0) || (noise && busyE && $urandom_range(3) == 0);
            bus.abort    = abortNow;
            bus.in_valid = v;
            bus.in_data  = data;
            bus.pps      = align ? ((ppsAt >= 1) && (c >= ppsAt)) : 1'($urandom_range(1));
            if (c == 0) begin
                bus.cfg_pps_align = align;
                bus.cfg_count     = CNT_W'(n);
            end else if (noise) begin
                bus.cfg_pps_align = 1'($urandom_range(1));
                bus.cfg_count     = CNT_W'($urandom_range(0, 20));
            end

            if (c == 0) begin
                if (abortNow) begin
                    stopped  = 1'b1;
                    endCycle = 0;
                end else begin
                    expCnt = '0;
                    expTo  = 1'b0;
                    if (!align) winStart = 1;
                end
            end else begin
                if (inRun && v) begin
                    expQ.push_back(data);
                    passed++;
                    if (expCnt != '1) expCnt = expCnt + 1;
                    if (n != 0 && passed == n) begin
                        stopped  = 1'b1;
                        endCycle = c + 1;
                        doneAt   = c + 1;
                    end
                end
                if (resetNow) begin
                    stopped  = 1'b1;
                    endCycle = c;
                    doneAt   = -1;
                    expCnt   = '0;
                    expTo    = 1'b0;
                end else if (abortNow) begin
                    stopped  = 1'b1;
                    endCycle = c;
                    if (doneAt > c) doneAt = -1;
                end else if (inWait) begin
                    if (c == ppsAt) begin
                        winStart = c + 1;
                    end else if (c == TOC) begin
                        stopped  = 1'b1;
                        endCycle = c;
                        expTo    = 1'b1;
                    end
                end
            end

            if (endCycle >= 0 && c == endCycle + 1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            nChecks++;
            $display("[TB] FAIL captureBound: actual=no end after %0d cycles required=capture end", MAXC);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic checkOutput();
        @(negedge clock);
        #1;
        check("samplesDrained", 64'(expQ.size()), 64'(0));
        check("statusDrained", 64'(statusQ.size()), 64'(0));
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.cfg_pps_align = 1'b0;
        bus.cfg_count     = '0;
        bus.pps           = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        reset             = 1'b1;
        repeat (2) tick();
        monOn = 1'b1;
        idle(5);

        applyStimulus(5,   1'b0, 0,    -1,   -1, 100, 1'b0);
        idle(3);
        applyStimulus(3,   1'b1, 50,   -1,   -1, 100, 1'b0);
        idle(2);
        applyStimulus(4,   1'b1, 1000, -1,   -1, 100, 1'b0);
        idle(2);
        applyStimulus(2,   1'b1, TOC,  -1,   -1, 100, 1'b0);
        idle(2);
        applyStimulus(0,   1'b0, 0,    1000, -1, 100, 1'b0);
        idle(2);
        applyStimulus(5,   1'b0, 0,    0,    -1, 100, 1'b0);
        idle(2);
        applyStimulus(4,   1'b0, 0,    -1,   -1, 100, 1'b1);
        idle(2);
        applyStimulus(4,   1'b0, 0,    4,    -1, 100, 1'b1);
        idle(2);
        applyStimulus(100, 1'b0, 0,    -1,   41, 100, 1'b0);
        idle(3);

        for (int i = 0; i < 14; i++) begin
            int n, ppsAt, abortAt, resetAt, pct;
            bit align;
            n       = $urandom_range(0, 12);
            align   = 1'($urandom_range(1));
            ppsAt   = $urandom_range(1, 90);
            pct     = $urandom_range(30, 100);
            abortAt = (n == 0) ? $urandom_range(5, 60) : (($urandom_range(1) == 1) ? $urandom_range(1, 60) : -1);
            resetAt = ($urandom_range(9) == 0) ? $urandom_range(2, 40) : -1;
            applyStimulus(n, align, ppsAt, abortAt, resetAt, pct, 1'b1);
            idle($urandom_range(1, 4));
        end

        idle(2);
        checkOutput();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
